exc_pipe: RTL and testbench

Exception-tracking pipeline registers for the IF→ID→EXE path of the 5-stage CPU. The block carries per-instruction exception flags, PC and delay-slot state from fetch to execute. It presents them to the CP0 register file as a 7-bit exception vector, branch-delay bit, EPC candidate and bad address. On a CP0-accepted exception, interrupt or ERET it flushes the younger stages and issues a PC redirect.

---
 rtl/exc_pipe.sv | 128 ++++++++++++
 tb/tb_exc_pipe.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/exc_pipe.sv
// Exception-tracking IF->ID->EXE pipeline registers: carries PC, fetch-alignment and decode flags
// to EXE, builds the CP0 exception vector and drives flush/redirect on exception, interrupt or ERET.
module exc_pipe #(
    parameter logic [31:0] EXC_ENTRY = 32'hBFC0_0380
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_valid,
    input  logic [31:0] if_pc,
    output logic        id_allowin,
    input  logic        id_ready_go,
    input  logic        id_ri,
    input  logic        id_syscall,
    input  logic        id_break,
    input  logic        id_eret,
    input  logic        id_branch,
    input  logic        exe_ready_go,
    input  logic        mem_allowin,
    input  logic        exe_ov,
    input  logic        exe_adel,
    input  logic        exe_ades,
    input  logic [31:0] exe_vaddr,
    input  logic        ex_int_handle,
    input  logic [31:0] epc_value,
    output logic        exe_valid,
    output logic        exe_fire,
    output logic [6:0]  exc_vec,
    output logic        exc_bd,
    output logic [31:0] epc_out,
    output logic [31:0] badvaddr_out,
    output logic        eret_out,
    output logic        exe_cancel,
    output logic        flush,
    output logic [31:0] redirect_pc
);

    logic        r_id_valid;
    logic [31:0] r_id_pc;
    logic        r_id_pc_adel;

    logic        r_exe_valid;
    logic [31:0] r_exe_pc;
    logic        r_exe_pc_adel;
    logic        r_exe_ri;
    logic        r_exe_sys;
    logic        r_exe_bp;
    logic        r_exe_eret;
    logic        r_exe_bd;
    logic        r_branch_pending;

    logic        w_exe_allowin;
    logic        w_if_to_id;
    logic        w_id_to_exe;
    logic        w_early_exc;
    logic [6:0]  w_vec_raw;

    assign w_exe_allowin = !r_exe_valid | (exe_ready_go & mem_allowin);
    assign id_allowin    = !r_id_valid | (id_ready_go & w_exe_allowin);
    assign w_if_to_id    = if_valid & id_allowin & !flush;
    assign w_id_to_exe   = r_id_valid & id_ready_go & w_exe_allowin & !flush;

    assign exe_valid = r_exe_valid;
    assign exe_fire  = r_exe_valid & exe_ready_go & mem_allowin;

    // Exceptions raised earlier in the pipe mask the ones EXE itself detects.
    assign w_early_exc = r_exe_pc_adel | r_exe_ri | r_exe_sys | r_exe_bp;
    assign w_vec_raw   = {r_exe_pc_adel, r_exe_ri, exe_ov & !w_early_exc, r_exe_sys, r_exe_bp,
                          exe_adel & !w_early_exc, exe_ades & !w_early_exc};
    assign exc_vec     = {7{r_exe_valid}} & w_vec_raw;

    assign exc_bd       = r_exe_valid & r_exe_bd;
    assign epc_out      = r_exe_bd ? (r_exe_pc - 32'd4) : r_exe_pc;
    assign badvaddr_out = exc_vec[6] ? r_exe_pc : exe_vaddr;
    assign eret_out     = r_exe_valid & r_exe_eret & ~|exc_vec;
    assign exe_cancel   = r_exe_valid & (|exc_vec | ex_int_handle);
    assign flush        = exe_fire & (ex_int_handle | eret_out);
    assign redirect_pc  = ex_int_handle ? EXC_ENTRY : epc_value;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_id_valid       <= 1'b0;
            r_id_pc          <= 32'd0;
            r_id_pc_adel     <= 1'b0;
            r_exe_valid      <= 1'b0;
            r_exe_pc         <= 32'd0;
            r_exe_pc_adel    <= 1'b0;
            r_exe_ri         <= 1'b0;
            r_exe_sys        <= 1'b0;
            r_exe_bp         <= 1'b0;
            r_exe_eret       <= 1'b0;
            r_exe_bd         <= 1'b0;
            r_branch_pending <= 1'b0;
        end else begin
            if (flush) begin
                r_id_valid <= 1'b0;
            end else if (id_allowin) begin
                r_id_valid <= if_valid;
            end
            if (w_if_to_id) begin
                r_id_pc      <= if_pc;
                r_id_pc_adel <= |if_pc[1:0];
            end

            if (flush) begin
                r_exe_valid <= 1'b0;
            end else if (w_exe_allowin) begin
                r_exe_valid <= w_id_to_exe;
            end
            // A misaligned fetch never decoded a real instruction, so its flags are dropped.
            if (w_id_to_exe) begin
                r_exe_pc      <= r_id_pc;
                r_exe_pc_adel <= r_id_pc_adel;
                r_exe_ri      <= id_ri & !r_id_pc_adel;
                r_exe_sys     <= id_syscall & !r_id_pc_adel;
                r_exe_bp      <= id_break & !r_id_pc_adel;
                r_exe_eret    <= id_eret & !r_id_pc_adel;
                r_exe_bd      <= r_branch_pending;
            end

            if (flush) begin
                r_branch_pending <= 1'b0;
            end else if (w_id_to_exe) begin
                r_branch_pending <= id_branch;
            end
        end
    end

endmodule

// File: tb/tb_exc_pipe.sv
// Scoreboard bench for exc_pipe: a transaction-level pipeline model predicts each EXE retirement;
// a monitor pops and compares whenever the DUT fires.
module tb_exc_pipe;
    localparam logic [31:0] ENTRY = 32'hBFC0_0380;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, if_valid, id_allowin, id_ready_go;
    logic        id_ri, id_syscall, id_break, id_eret, id_branch;
    logic        exe_ready_go, mem_allowin, exe_ov, exe_adel, exe_ades, ex_int_handle;
    logic [31:0] if_pc, exe_vaddr, epc_value;
    logic        exe_valid, exe_fire, exc_bd, eret_out, exe_cancel, flush;
    logic [6:0]  exc_vec;
    logic [31:0] epc_out, badvaddr_out, redirect_pc;

    exc_pipe #(.EXC_ENTRY(ENTRY)) dut (
        .clk(clk), .rst(rst), .if_valid(if_valid), .if_pc(if_pc), .id_allowin(id_allowin),
        .id_ready_go(id_ready_go), .id_ri(id_ri), .id_syscall(id_syscall), .id_break(id_break),
        .id_eret(id_eret), .id_branch(id_branch), .exe_ready_go(exe_ready_go),
        .mem_allowin(mem_allowin), .exe_ov(exe_ov), .exe_adel(exe_adel), .exe_ades(exe_ades),
        .exe_vaddr(exe_vaddr), .ex_int_handle(ex_int_handle), .epc_value(epc_value),
        .exe_valid(exe_valid), .exe_fire(exe_fire), .exc_vec(exc_vec), .exc_bd(exc_bd),
        .epc_out(epc_out), .badvaddr_out(badvaddr_out), .eret_out(eret_out),
        .exe_cancel(exe_cancel), .flush(flush), .redirect_pc(redirect_pc)
    );

    typedef struct packed {
        logic [31:0] pc;
        logic        br, ri, sys, bp, eret;
    } instr_t;

    typedef struct packed {
        logic [6:0]  vec;
        logic        bd;
        logic [31:0] epc, bad;
        logic        eret, cancel, flush;
        logic [31:0] rpc;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;
    int   checks = 0;
    int   errors = 0;
    bit   mon_en = 1'b0;

    // Stimulus knobs for the current cycle.
    logic        s_if_valid, s_br, s_ri, s_sys, s_bp, s_eret, s_id_rg, s_exe_rg, s_mem;
    logic        s_ov, s_adel, s_ades, s_int, s_rst;
    logic [31:0] s_pc, s_vaddr, s_epc;

    // Model: instruction records held in ID and EXE plus the pending-branch flag.
    logic   m_id_v = 1'b0, m_exe_v = 1'b0, m_exe_bd = 1'b0, m_bp = 1'b0;
    instr_t m_id = '0, m_exe = '0;
    logic   n_id_v, n_exe_v, n_exe_bd, n_bp;
    instr_t n_id, n_exe;
    logic   e_fire = 1'b0, e_exe_valid = 1'b0, e_id_allowin = 1'b1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic set_idle();
        s_if_valid = 0; s_pc = 0; s_br = 0; s_ri = 0; s_sys = 0; s_bp = 0; s_eret = 0;
        s_id_rg = 1; s_exe_rg = 1; s_mem = 1; s_ov = 0; s_adel = 0; s_ades = 0;
        s_vaddr = 0; s_int = 0; s_epc = 0; s_rst = 0;
    endtask

    task automatic offer(input logic [31:0] pc, input logic br, input logic ri, input logic sys,
                         input logic bp, input logic er);
        s_if_valid = 1; s_pc = pc; s_br = br; s_ri = ri; s_sys = sys; s_bp = bp; s_eret = er;
    endtask

    task automatic drive();
        logic [6:0] v;
        exp_t       e;
        logic       exe_allow;
        instr_t     ni;
        rst = s_rst; if_valid = s_if_valid; if_pc = s_pc; id_ready_go = s_id_rg;
        id_ri = m_id.ri; id_syscall = m_id.sys; id_break = m_id.bp; id_eret = m_id.eret;
        id_branch = m_id.br; exe_ready_go = s_exe_rg; mem_allowin = s_mem;
        exe_ov = s_ov; exe_adel = s_adel; exe_ades = s_ades; exe_vaddr = s_vaddr;
        ex_int_handle = s_int; epc_value = s_epc;

        exe_allow = !m_exe_v || (s_exe_rg && s_mem);
        e_fire = m_exe_v && s_exe_rg && s_mem;
        e_exe_valid = m_exe_v;
        e_id_allowin = !m_id_v || (s_id_rg && exe_allow);

        // Earliest exception wins: bad fetch, then decode, then EXE-detected ones.
        if (!m_exe_v) v = 7'd0;
        else if (m_exe.pc[1:0] != 2'b00) v = 7'b1000000;
        else if (m_exe.ri || m_exe.sys || m_exe.bp) v = {1'b0, m_exe.ri, 1'b0, m_exe.sys, m_exe.bp, 2'b00};
        else v = {2'b00, s_ov, 2'b00, s_adel, s_ades};
        e.vec = v;
        e.bd = m_exe_bd;
        e.epc = m_exe_bd ? m_exe.pc - 32'd4 : m_exe.pc;
        e.bad = (m_exe.pc[1:0] != 2'b00) ? m_exe.pc : s_vaddr;
        e.eret = m_exe_v && m_exe.eret && (v == 7'd0);
        e.cancel = m_exe_v && ((v != 7'd0) || s_int);
        e.flush = e_fire && (s_int || e.eret);
        e.rpc = s_int ? ENTRY : s_epc;
        if (e_fire && mon_en) sb_q.push_back(e);

        n_id_v = m_id_v; n_id = m_id; n_exe_v = m_exe_v; n_exe = m_exe;
        n_exe_bd = m_exe_bd; n_bp = m_bp;
        if (s_rst) begin
            n_id_v = 0; n_id = '0; n_exe_v = 0; n_exe = '0; n_exe_bd = 0; n_bp = 0;
        end else if (e.flush) begin
            n_id_v = 0; n_exe_v = 0; n_bp = 0;
        end else begin
            if (m_id_v && s_id_rg && exe_allow) begin
                n_exe = m_id; n_exe_v = 1; n_exe_bd = m_bp; n_bp = m_id.br;
            end else if (exe_allow) begin
                n_exe_v = 0;
            end
            if (s_if_valid && e_id_allowin) begin
                ni.pc = s_pc; ni.br = s_br; ni.ri = s_ri; ni.sys = s_sys; ni.bp = s_bp;
                ni.eret = s_eret;
                n_id = ni; n_id_v = 1;
            end else if (e_id_allowin) begin
                n_id_v = 0;
            end
        end
    endtask

    task automatic commit();
        @(posedge clk);
        m_id_v = n_id_v; m_id = n_id; m_exe_v = n_exe_v; m_exe = n_exe;
        m_exe_bd = n_exe_bd; m_bp = n_bp;
        #1;
    endtask

    task automatic step();
        drive();
        commit();
    endtask

    task automatic drain();
        set_idle();
        repeat (3) step();
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            chk("exe_fire", exe_fire, e_fire);
            chk("exe_valid", exe_valid, e_exe_valid);
            chk("id_allowin", id_allowin, e_id_allowin);
            if (e_fire && sb_q.size() > 0) begin
                mon_e = sb_q.pop_front();
                if (exe_fire) begin
                    chk("exc_vec", exc_vec, mon_e.vec);
                    chk("exc_bd", exc_bd, mon_e.bd);
                    chk("epc_out", epc_out, mon_e.epc);
                    chk("badvaddr", badvaddr_out, mon_e.bad);
                    chk("eret_out", eret_out, mon_e.eret);
                    chk("exe_cancel", exe_cancel, mon_e.cancel);
                    chk("flush", flush, mon_e.flush);
                    if (mon_e.flush) chk("redirect_pc", redirect_pc, mon_e.rpc);
                end
            end else begin
                chk("flush_nofire", flush, 0);
                if (!e_exe_valid) begin
                    chk("exc_vec_idle", exc_vec, 0);
                    chk("cancel_idle", exe_cancel, 0);
                    chk("eret_idle", eret_out, 0);
                end
            end
        end
    end

    initial begin
        set_idle();
        s_rst = 1;
        step();
        step();
        mon_en = 1;

        // Reset state
        set_idle();
        drive();
        @(negedge clk);
        chk("rst_exc_vec", exc_vec, 0);
        chk("rst_flush", flush, 0);
        chk("rst_exe_fire", exe_fire, 0);
        chk("rst_exc_bd", exc_bd, 0);
        chk("rst_eret", eret_out, 0);
        chk("rst_cancel", exe_cancel, 0);
        chk("rst_exe_valid", exe_valid, 0);
        chk("rst_id_allowin", id_allowin, 1);
        commit();

        // Straight-line flow
        offer(32'hBFC0_0000, 0, 0, 0, 0, 0); step();
        offer(32'hBFC0_0004, 0, 0, 0, 0, 0); step();
        offer(32'hBFC0_0008, 0, 0, 0, 0, 0); drive();
        @(negedge clk);
        chk("line_epc", epc_out, 32'hBFC0_0000);
        chk("line_vec", exc_vec, 0);
        commit();
        drain();

        // Syscall in a branch delay slot, taken as an exception
        offer(32'h100, 1, 0, 0, 0, 0); step();
        offer(32'h104, 0, 0, 1, 0, 0); step();
        set_idle(); step();
        offer(32'h108, 0, 0, 0, 0, 0); s_int = 1; drive();
        @(negedge clk);
        chk("sys_vec", exc_vec, 7'b0001000);
        chk("sys_bd", exc_bd, 1);
        chk("sys_epc", epc_out, 32'h100);
        chk("sys_flush", flush, 1);
        chk("sys_redirect", redirect_pc, ENTRY);
        commit();
        set_idle(); drive();
        @(negedge clk);
        chk("sys_exe_squash", exe_valid, 0);
        chk("sys_id_empty", id_allowin, 1);
        commit();
        drain();

        // Misaligned fetch masks decode and EXE exceptions
        offer(32'h202, 0, 1, 0, 0, 0); step();
        set_idle(); step();
        s_adel = 1; s_vaddr = 32'h55; drive();
        @(negedge clk);
        chk("adel_vec", exc_vec, 7'b1000000);
        chk("adel_bad", badvaddr_out, 32'h202);
        commit();
        drain();

        // Store address error
        offer(32'h500, 0, 0, 0, 0, 0); step();
        set_idle(); step();
        s_ades = 1; s_vaddr = 32'h1003; drive();
        @(negedge clk);
        chk("ades_vec", exc_vec, 7'b0000001);
        chk("ades_bad", badvaddr_out, 32'h1003);
        chk("ades_cancel", exe_cancel, 1);
        commit();
        drain();

        // ERET redirects to EPC and squashes the following instruction
        offer(32'h300, 0, 0, 0, 0, 1); step();
        offer(32'h304, 0, 0, 0, 0, 0); step();
        set_idle(); s_epc = 32'h400; drive();
        @(negedge clk);
        chk("eret_out", eret_out, 1);
        chk("eret_flush", flush, 1);
        chk("eret_redirect", redirect_pc, 32'h400);
        commit();
        set_idle(); drive();
        @(negedge clk);
        chk("eret_squash", exe_valid, 0);
        commit();
        drain();

        // Stall then reset
        offer(32'h600, 0, 0, 0, 0, 0); step();
        set_idle(); step();
        for (int i = 0; i < 3; i++) begin
            s_exe_rg = 0; drive();
            @(negedge clk);
            chk("stall_valid", exe_valid, 1);
            chk("stall_epc", epc_out, 32'h600);
            chk("stall_flush", flush, 0);
            commit();
        end
        s_rst = 1; step();
        set_idle(); drive();
        @(negedge clk);
        chk("postrst_valid", exe_valid, 0);
        chk("postrst_vec", exc_vec, 0);
        commit();

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            s_if_valid = ($urandom_range(99) < 80);
            s_pc = $urandom() & 32'hFFFF_FFFC;
            if ($urandom_range(99) < 10) s_pc[1:0] = 2'($urandom_range(3));
            s_br = ($urandom_range(99) < 20);
            s_ri = ($urandom_range(99) < 4);
            s_sys = ($urandom_range(99) < 4);
            s_bp = ($urandom_range(99) < 4);
            s_eret = ($urandom_range(99) < 5);
            s_id_rg = ($urandom_range(99) < 85);
            s_exe_rg = ($urandom_range(99) < 80);
            s_mem = ($urandom_range(99) < 85);
            s_ov = ($urandom_range(99) < 5);
            s_adel = ($urandom_range(99) < 5);
            s_ades = ($urandom_range(99) < 5);
            s_int = ($urandom_range(99) < 8);
            s_vaddr = $urandom();
            s_epc = $urandom();
            s_rst = ($urandom_range(99) < 1);
            step();
        end

        set_idle();
        step();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
